multichannel_delay_line: RTL and testbench
==========================================

Name: multichannel_delay_line

Overview:
- Per-channel programmable integer sample delay for the PCM path, NUM_CH channels.
- Sits between the PCM decimation front end and the delay-and-sum beamformer; each channel is steered by its own delay.
- Generalises the single-channel delay line with:
  - parametrised sample width, depth and channel count;
  - a sample-valid strobe instead of per-clock shifting;
  - glitch-free delay reload;
  - zero-fill warm-up;
  - a registered, valid-qualified output.

Parameters:
- WIDTH, 19, PCM sample width in bits (signed two's complement, passed through unmodified).
- NUM_CH, 8, number of independent channels (1..32).
- MAX_DELAY, 64, buffer depth per channel. Must be a power of two, >= 2. Legal delay range is 0..MAX_DELAY-1.
- DW, $clog2(MAX_DELAY), width of each delay lane (derived; not overridden).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  one new sample per channel is present on in_data this cycle.
- in_data  input  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- delay  input  NUM_CH*DW  requested delay in samples; channel c occupies bits [c*DW +: DW].
- delay_load  input  1  capture the delay bus into the shadow registers.
- out_valid  output  1  out_data holds a new delayed sample set.
- out_data  output  NUM_CH*WIDTH  delayed samples, same lane packing as in_data.
- fill_level  output  DW+1  number of samples written since reset, saturating at MAX_DELAY.

Behaviour:
- Reset: one clock, reset is synchronous and active-high on rst.
  - Outputs: out_valid=0, out_data=0, fill_level=0.
  - Internal state: write pointer=0, shadow and active delays=0.
  - Buffer RAM contents are not cleared; the fill logic masks stale data.
- Storage and pointer:
  - One circular buffer per channel, MAX_DELAY entries x WIDTH.
  - A single shared write pointer wp, DW bits, wraps naturally from MAX_DELAY-1 to 0.
- Sample accept: on a cycle with in_valid=1, for every channel c:
  - Write in_data[c] to buf_c[wp].
  - Read address ra_c = (wp - D_c) mod MAX_DELAY, where D_c is the active delay.
  - D_c=0 bypasses: out sample = current in_data[c] (read-during-write returns new data).
  - If fill_level < D_c, the out sample is 0; otherwise it is buf_c[ra_c].
  - Then wp += 1, and fill_level += 1 unless already MAX_DELAY.
- Latency: out_valid asserts exactly 1 clock after an accepted in_valid, for 1 cycle.
  - out_data is held between strobes.
  - Back-to-back in_valid gives back-to-back out_valid.
- Transfer function: with constant D_c, the out sample for input index n equals x_c[n-D_c], or 0 if n < D_c.
- Delay reload:
  - delay_load=1 captures the delay bus into shadow registers.
  - Shadow values are copied to the active delays at the next accepted sample, before the read address is computed.
  - All channels switch on the same sample; there are no mixed old/new delays within one output set.
  - delay_load and in_valid in the same cycle: the new delays apply to that same sample.
  - Multiple loads before a sample: the last one wins.
- Delay reduction mid-stream: legal. Samples between the old and new tap are skipped, with no zero insertion.
- Delay increase mid-stream: legal. Previously output history is repeated from RAM if fill_level allows; otherwise 0.
- in_valid=0: no write, no pointer movement, out_valid=0.
- Reset mid-stream:
  - Pending shadow delays are discarded.
  - The first output after reset obeys warm-up zero-fill.
- Arithmetic: no sign extension or scaling. Pointer subtraction is modulo 2^DW.

Test Plan:
- Ramp, D=0 on all channels: in_data ch c = 100*c + n, in_valid every cycle. Required: out_data equals the input one clock later; out_valid tracks in_valid delayed by 1.
- Warm-up: ch0 D=5, ch1 D=63. Inject samples 1,2,3,... Required:
  - ch0 outputs 0 for the first 5 outputs, then 1,2,3...
  - ch1 outputs 0 for 63 outputs, then 1.
  - fill_level saturates at 64.
- Sparse valid: in_valid every 4th cycle, ch2 D=3. Required: ch2 output lags by exactly 3 strobes regardless of the idle cycles; out_data holds between strobes.
- Wrap-around: run 200 samples, ch3 D=63. Required: out = x[n-63] across the pointer wrap at 64 and 128.
- Reload: ch0 D changes 10 -> 4 at sample 50, with delay_load asserted in the same cycle as in_valid. Required:
  - output at sample 50 = x[46]; at sample 49 = x[39];
  - all channels switch on sample 50.
- Reset at sample 30, then restart with D=2. Required: the first 2 outputs are 0, then the new samples; there is no leakage of pre-reset data.

Source files
------------

// File: rtl/multichannel_delay_line_if.sv
// Sample bus between the PCM decimator and the per-channel delay line.
// The master drives samples and delay programming; the slave returns delayed sample sets.
interface multichannel_delay_line_if #(
    parameter int WIDTH     = 19,
    parameter int NUM_CH    = 8,
    parameter int MAX_DELAY = 64
);
    localparam int DW = $clog2(MAX_DELAY);

    logic                    in_valid;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH*DW-1:0]    delay;
    logic                    delay_load;
    logic                    out_valid;
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic [DW:0]             fill_level;

    modport master (
        output in_valid, in_data, delay, delay_load,
        input  out_valid, out_data, fill_level
    );

    modport slave (
        input  in_valid, in_data, delay, delay_load,
        output out_valid, out_data, fill_level
    );
endinterface

// File: rtl/multichannel_delay_line.sv
// Per-channel programmable integer sample delay with a shared write pointer,
// shadowed delay reload, zero-filled warm-up and a registered valid-qualified output.
module multichannel_delay_line #(
    parameter int WIDTH     = 19,
    parameter int NUM_CH    = 8,
    parameter int MAX_DELAY = 64,
    localparam int DW       = $clog2(MAX_DELAY)
) (
    input logic                      clk,
    input logic                      rst,
    multichannel_delay_line_if.slave bus
);

    localparam logic [DW:0] FILL_MAX = (DW+1)'(MAX_DELAY);

    // A zero delay bypasses the RAM; taps reaching behind the first written sample read as 0.
    function automatic logic signed [WIDTH-1:0] tap_select(
        input logic signed [WIDTH-1:0] x_new,
        input logic signed [WIDTH-1:0] x_old,
        input logic [DW-1:0]           d,
        input logic [DW:0]             fill
    );
        if (d == '0) return x_new;
        if (fill < {1'b0, d}) return '0;
        return x_old;
    endfunction

    function automatic logic [DW:0] fill_inc(input logic [DW:0] f);
        return (f == FILL_MAX) ? f : f + 1'b1;
    endfunction

    logic signed [WIDTH-1:0] mem [NUM_CH][MAX_DELAY];
    logic [DW-1:0]           shadow [NUM_CH];
    logic [DW-1:0]           wp_p0;
    logic [DW:0]             fill_p0;

    logic [DW-1:0]           d_p0   [NUM_CH];
    logic [DW-1:0]           ra_p0  [NUM_CH];
    logic signed [WIDTH-1:0] x_p0   [NUM_CH];
    logic signed [WIDTH-1:0] tap_p0 [NUM_CH];

    logic                    vld_p1;
    logic signed [WIDTH-1:0] data_p1 [NUM_CH];

    // Stage p0: a load in the same cycle as a sample takes effect on that sample.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            d_p0[c]   = bus.delay_load ? bus.delay[c*DW +: DW] : shadow[c];
            ra_p0[c]  = wp_p0 - d_p0[c];
            x_p0[c]   = $signed(bus.in_data[c*WIDTH +: WIDTH]);
            tap_p0[c] = tap_select(x_p0[c], mem[c][ra_p0[c]], d_p0[c], fill_p0);
        end
    end

    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mem[c][wp_p0] <= x_p0[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_p0   <= '0;
            fill_p0 <= '0;
            vld_p1  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                shadow[c]  <= '0;
                data_p1[c] <= '0;
            end
        end else begin
            vld_p1 <= bus.in_valid;
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.delay_load) shadow[c] <= bus.delay[c*DW +: DW];
                if (bus.in_valid) data_p1[c] <= tap_p0[c];
            end
            if (bus.in_valid) begin
                wp_p0   <= wp_p0 + 1'b1;
                fill_p0 <= fill_inc(fill_p0);
            end
        end
    end

    // Stage p1: registered output, held between strobes.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign bus.out_data[c*WIDTH +: WIDTH] = data_p1[c];
    end
    assign bus.out_valid  = vld_p1;
    assign bus.fill_level = fill_p0;

endmodule

// File: tb/tb_multichannel_delay_line.sv
// Self-checking bench for multichannel_delay_line: a hand-computed vector table,
// directed scenarios and randomized traffic against a sample-history reference model.
module tb_multichannel_delay_line;

    localparam int WIDTH     = 19;
    localparam int NUM_CH    = 8;
    localparam int MAX_DELAY = 64;
    localparam int DW        = 6;

    typedef logic signed [WIDTH-1:0] smp_t;

    typedef struct {
        bit v;
        bit ld;
        int d;
        int x;
        bit ev;
        int eo;
        int ef;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multichannel_delay_line_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .MAX_DELAY(MAX_DELAY)) bus ();

    multichannel_delay_line #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .MAX_DELAY(MAX_DELAY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: full input history since reset plus the programmed delays.
    smp_t hist [NUM_CH][1024];
    int   n_smp;
    int   m_fill;
    int   m_shadow [NUM_CH];
    smp_t m_out [NUM_CH];

    int   drv_d [NUM_CH];
    smp_t drv_x [NUM_CH];

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic smp_t out_ch(input int c);
        return smp_t'(bus.out_data[c*WIDTH +: WIDTH]);
    endfunction

    task automatic drive(input bit v, input bit ld);
        bus.in_valid   = v;
        bus.delay_load = ld;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.in_data[c*WIDTH +: WIDTH] = drv_x[c];
            bus.delay[c*DW +: DW]         = DW'(drv_d[c]);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.delay_load = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_fill_level", bus.fill_level, 0);
        for (int c = 0; c < NUM_CH; c++) chk($sformatf("rst_out_data[%0d]", c), out_ch(c), 0);
        rst    = 1'b0;
        n_smp  = 0;
        m_fill = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_shadow[c] = 0;
            m_out[c]    = '0;
        end
    endtask

    task automatic step(input bit v, input bit ld);
        drive(v, ld);
        if (ld) for (int c = 0; c < NUM_CH; c++) m_shadow[c] = drv_d[c];
        if (v) begin
            for (int c = 0; c < NUM_CH; c++) begin
                hist[c][n_smp] = drv_x[c];
                m_out[c] = (n_smp < m_shadow[c]) ? smp_t'(0) : hist[c][n_smp - m_shadow[c]];
            end
            n_smp++;
            if (m_fill < MAX_DELAY) m_fill++;
        end
        @(posedge clk);
        #1;
        chk("out_valid", bus.out_valid, v);
        for (int c = 0; c < NUM_CH; c++) chk($sformatf("out_data[%0d]", c), out_ch(c), m_out[c]);
        chk("fill_level", bus.fill_level, m_fill);
    endtask

    task automatic rand_delays();
        for (int c = 0; c < NUM_CH; c++) drv_d[c] = $urandom_range(0, MAX_DELAY-1);
    endtask

    task automatic rand_data();
        for (int c = 0; c < NUM_CH; c++) drv_x[c] = smp_t'($urandom);
    endtask

    vec_t tbl [10];

    initial begin
        tbl[0] = '{v:1, ld:1, d:2, x:10, ev:1, eo:0,  ef:1};
        tbl[1] = '{v:1, ld:0, d:2, x:20, ev:1, eo:0,  ef:2};
        tbl[2] = '{v:0, ld:0, d:2, x:99, ev:0, eo:0,  ef:2};
        tbl[3] = '{v:1, ld:0, d:2, x:30, ev:1, eo:10, ef:3};
        tbl[4] = '{v:1, ld:0, d:2, x:40, ev:1, eo:20, ef:4};
        tbl[5] = '{v:1, ld:1, d:0, x:50, ev:1, eo:50, ef:5};
        tbl[6] = '{v:0, ld:1, d:3, x:77, ev:0, eo:50, ef:5};
        tbl[7] = '{v:1, ld:0, d:3, x:60, ev:1, eo:30, ef:6};
        tbl[8] = '{v:1, ld:1, d:1, x:70, ev:1, eo:60, ef:7};
        tbl[9] = '{v:0, ld:0, d:1, x:0,  ev:0, eo:60, ef:7};

        rst = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            drv_d[c] = 0;
            drv_x[c] = '0;
        end
        drive(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Hand-computed table; channel c carries x+c.
        foreach (tbl[i]) begin
            for (int c = 0; c < NUM_CH; c++) begin
                drv_d[c] = tbl[i].d;
                drv_x[c] = smp_t'(tbl[i].x + c);
            end
            drive(tbl[i].v, tbl[i].ld);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].ev);
            for (int c = 0; c < NUM_CH; c++)
                chk($sformatf("tbl%0d_out_data[%0d]", i, c), out_ch(c),
                    (tbl[i].eo == 0) ? 0 : tbl[i].eo + c);
            chk($sformatf("tbl%0d_fill", i), bus.fill_level, tbl[i].ef);
        end

        // Ramp with zero delay.
        do_reset();
        for (int c = 0; c < NUM_CH; c++) drv_d[c] = 0;
        for (int k = 0; k < 20; k++) begin
            for (int c = 0; c < NUM_CH; c++) drv_x[c] = smp_t'(100*c + k);
            step(1'b1, k == 0);
        end
        step(1'b0, 1'b0);

        // Warm-up zero fill and fill_level saturation.
        do_reset();
        rand_delays();
        drv_d[0] = 5;
        drv_d[1] = 63;
        for (int k = 0; k < 70; k++) begin
            for (int c = 0; c < NUM_CH; c++) drv_x[c] = smp_t'(k + 1);
            step(1'b1, k == 0);
            if (k == 4)  chk("warm_ch0_last_zero", out_ch(0), 0);
            if (k == 5)  chk("warm_ch0_first", out_ch(0), 1);
            if (k == 62) chk("warm_ch1_last_zero", out_ch(1), 0);
            if (k == 63) chk("warm_ch1_first", out_ch(1), 1);
        end
        chk("warm_fill_sat", bus.fill_level, 64);

        // Sparse strobes.
        do_reset();
        rand_delays();
        drv_d[2] = 3;
        for (int k = 0; k < 40; k++) begin
            rand_data();
            step(k % 4 == 0, k == 0);
        end

        // Pointer wrap with the deepest tap.
        do_reset();
        rand_delays();
        drv_d[3] = 63;
        for (int k = 0; k < 200; k++) begin
            rand_data();
            step(1'b1, k == 0);
        end

        // Reload 10 -> 4 on ch0 at sample 50, same cycle as the sample.
        do_reset();
        rand_delays();
        drv_d[0] = 10;
        for (int k = 0; k < 60; k++) begin
            rand_data();
            drv_x[0] = smp_t'(1000 + k);
            if (k == 50) begin
                rand_delays();
                drv_d[0] = 4;
            end
            step(1'b1, k == 0 || k == 50);
            if (k == 49) chk("reload_s49", out_ch(0), 1039);
            if (k == 50) chk("reload_s50", out_ch(0), 1046);
        end

        // A pending load is dropped by reset.
        do_reset();
        for (int c = 0; c < NUM_CH; c++) drv_d[c] = 5;
        rand_data();
        step(1'b0, 1'b1);
        do_reset();
        rand_data();
        step(1'b1, 1'b0);
        chk("rst_discard_bypass", out_ch(0), drv_x[0]);

        // Reset mid-stream, then restart with D=2.
        do_reset();
        rand_delays();
        for (int k = 0; k < 30; k++) begin
            rand_data();
            step(1'b1, k == 0);
        end
        do_reset();
        for (int c = 0; c < NUM_CH; c++) drv_d[c] = 2;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < NUM_CH; c++) drv_x[c] = smp_t'(500 + 10*c + k);
            step(1'b1, k == 0);
            if (k < 2) chk($sformatf("restart_zero%0d", k), out_ch(5), 0);
            else       chk($sformatf("restart_s%0d", k), out_ch(5), 550 + k - 2);
        end

        // Randomized traffic with random reloads.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rand_data();
            rand_delays();
            step(($urandom % 4) != 0, ($urandom % 8) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
